// File: rtl/pipe_stall_ctrl.sv
// Hazard/multdiv sequencer for the 5-stage pipeline: load-use bubbles and multdiv launch/wait/writeback steering.
// Latency: combinational enables; multdiv with ready after N WAIT cycles stalls N+1 cycles, load-use costs 1.
// Backpressure: stalls PC/FD/DX while waiting on multdiv. Optional STALL_CNT_EN adds stall_count.
module pipe_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir_d,
    input  logic [31:0] ir_x,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        dx_bubble,
    output logic        xm_bubble,
    output logic        xm_sel_md,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_err
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_q, err_nxt;

    logic [4:0] op_d, rd_d, rs_d, rt_d;
    logic [4:0] op_x, rd_x, aluop_x;
    logic       x_is_md, x_is_load, load_use;
    logic       timeout_hit;
    logic       unused_ir_bits;

    assign op_d    = ir_d[31:27];
    assign rd_d    = ir_d[26:22];
    assign rs_d    = ir_d[21:17];
    assign rt_d    = ir_d[16:12];
    assign op_x    = ir_x[31:27];
    assign rd_x    = ir_x[26:22];
    assign aluop_x = ir_x[6:2];

    assign unused_ir_bits = ^{ir_d[11:0], ir_x[21:7], ir_x[1:0]};

    assign x_is_md   = (op_x == OP_ALU) && ((aluop_x == ALU_MUL) || (aluop_x == ALU_DIV));
    assign x_is_load = (op_x == OP_LW);
    // sw reads its data register through the rd field, so it counts as a use
    assign load_use  = x_is_load && (rd_x != 5'd0) &&
                       ((rs_d == rd_x) || (rt_d == rd_x) || ((op_d == OP_SW) && (rd_d == rd_x)));
    assign timeout_hit = (cnt == CNT_W'(MD_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        dx_en     = 1'b1;
        dx_bubble = 1'b0;
        xm_bubble = 1'b0;
        xm_sel_md = 1'b0;
        md_start  = 1'b0;
        md_busy   = 1'b0;
        md_err    = 1'b0;
        case (state)
            IDLE: begin
                err_nxt = 1'b0;
                if (x_is_md) begin
                    md_start  = 1'b1;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_en     = 1'b0;
                    xm_bubble = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end else if (load_use) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_bubble = 1'b1;
                end
            end
            WAIT: begin
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                dx_en     = 1'b0;
                xm_bubble = 1'b1;
                md_busy   = 1'b1;
                cnt_nxt   = cnt + 1'b1;
                // a real result wins over a timeout landing on the same cycle
                if (md_ready) begin
                    err_nxt   = md_exception;
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                xm_sel_md = 1'b1;
                md_err    = err_q;
                err_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // outputs sit at their idle values while reset is held, whatever is in X
        if (!reset) begin
            pc_en     = 1'b1;
            fd_en     = 1'b1;
            dx_en     = 1'b1;
            dx_bubble = 1'b0;
            xm_bubble = 1'b0;
            xm_sel_md = 1'b0;
            md_start  = 1'b0;
            md_busy   = 1'b0;
            md_err    = 1'b0;
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!pc_en && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Hazard and multi-cycle sequencing controller for the 5-stage pipeline (PC, FD, DX, XM, MW latches). It stalls the PC/FD/DX latches and inserts bubbles for load-use hazards. It also launches and waits on the iterative multdiv unit for mul/div in X, then steers the multdiv result into the XM latch. It sits beside the datapath, decodes IR_D/IR_X, and drives only the latch enables and the bubble/select lines.

Parameters:
MD_TIMEOUT, 40, max cycles to wait for md_ready after md_start before forcing completion with error
CNT_W, 6, width of the internal wait counter; must satisfy 2^CNT_W > MD_TIMEOUT

Ports:
clock  input  1  master clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
ir_d  input  32  instruction in FD latch (decode stage)
ir_x  input  32  instruction in DX latch (execute stage)
md_ready  input  1  multdiv result valid (pulse)
md_exception  input  1  multdiv exception (div by zero), valid with md_ready
pc_en  output  1  PC register enable
fd_en  output  1  FD latch enable
dx_en  output  1  DX latch enable
dx_bubble  output  1  load nop (32'b0) into DX instead of ir_d
xm_bubble  output  1  load nop into XM instead of X-stage outputs
xm_sel_md  output  1  XM O input takes multdiv result instead of ALU_out
md_start  output  1  one-cycle launch pulse to multdiv
md_busy  output  1  high in WAIT
md_err  output  1  exception/timeout flag accompanying xm_sel_md

Behaviour:
- Decode: opcode=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], aluop=[6:2]. The X instruction is multdiv when its opcode=00000 and its aluop is 00110 (mul) or 00111 (div). The X instruction is a load when its opcode=01000.
- Reset (reset=0, async): state=IDLE, cnt=0. Outputs: pc_en=fd_en=dx_en=1; dx_bubble, xm_bubble, xm_sel_md, md_start, md_busy, md_err all 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, multdiv in X:
  - md_start=1 (combinational, one cycle).
  - pc_en=fd_en=dx_en=0, xm_bubble=1.
  - Next state WAIT, cnt<=0.
- IDLE, no multdiv, load-use hazard:
  - Hazard condition: X is a load, rd_x!=0, and (rs_d==rd_x, or rt_d==rd_x, or D is sw [opcode 00111] with rd_d==rd_x).
  - pc_en=fd_en=0, dx_en=1, dx_bubble=1 for exactly one cycle. Stay in IDLE.
- IDLE, neither: all enables 1, no bubbles.
- WAIT:
  - pc_en=fd_en=dx_en=0, xm_bubble=1, md_busy=1, cnt<=cnt+1.
  - md_ready=1: go to DONE; register md_err<=md_exception.
  - Else if cnt==MD_TIMEOUT-1: go to DONE, md_err<=1.
  - md_ready arriving in the same cycle the timeout hits takes priority (md_err=md_exception).
- DONE (one cycle):
  - All enables 1, xm_sel_md=1, md_err as registered; the multdiv instruction advances X->M.
  - Next state IDLE; md_err clears on exit.
- md_ready outside WAIT is ignored, including a ready in the md_start cycle.
- Multdiv hazard detection has priority over load-use; no load-use check in WAIT/DONE.
- A new multdiv in X on the cycle after DONE is a fresh instruction and is launched normally (back-to-back mul supported).
- Latency: a multdiv with ready after N WAIT cycles stalls the front end N+1 cycles. A load-use hazard costs 1 cycle.
- Reset asserted mid-WAIT: immediate return to IDLE; no md_start is reissued until a multdiv is seen again in IDLE.

Optional Feature:
STALL_CNT_EN: adds output stall_count[31:0]. It increments every cycle pc_en=0, saturates at 32'hFFFFFFFF, and clears on reset. Without the macro, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset held low 3 cycles, released -> pc_en=fd_en=dx_en=1, all other outputs 0 every cycle until stimulus.
- ir_x=lw $5 (opcode 01000, rd=5), ir_d=add rs=5 -> one cycle pc_en=fd_en=0, dx_bubble=1; next cycle all enables 1. Same stimulus with rd=0 -> no stall.
- ir_x=mul (aluop 00110), md_ready pulsed 16 cycles after md_start -> md_start one cycle, md_busy 16 cycles, then one DONE cycle with xm_sel_md=1, md_err=0; pc_en low 17 cycles total.
- div with md_ready+md_exception after 5 cycles -> DONE cycle with md_err=1; md_err=0 next cycle.
- md_ready never asserted, MD_TIMEOUT=40 -> DONE after 40 WAIT cycles with md_err=1; pipeline resumes.
- Reset dropped during WAIT at cycle 7 -> state IDLE immediately, md_busy=0, enables 1, no spurious md_start. With STALL_CNT_EN, stall_count matches total pc_en-low cycles.
